apb_mem_ctrl: RTL and testbench

- APB3 slave front-end that sequences the 16x8 byte memory macro: decodes APB setup/access phases, drives the memory's write-enable, read-enable, address and write data, and returns data with PREADY/PSLVERR.
- Sits between the APB interconnect and the memory macro; the memory's pclk and rst_n are the same nets as this block's.
- Guarantees the memory's write-enable is a single-cycle pulse with at least one low cycle between writes, as the macro's write edge-detect requires.
- Absorbs the macro's one-cycle registered read latency with one wait state.

---
 rtl/apb_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_apb_mem_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_ctrl.sv
// apb_mem_ctrl: APB3 slave front-end for the 16x8 byte memory macro.
// Sequences single-cycle write/read strobes to the macro, inserting one wait
// state per transfer to absorb the macro's registered read latency.
// Optional build macro: APB_MEM_ADDR_CHECK_EN -- when defined, addresses at or
// above MEM_DEPTH complete with PSLVERR and never touch the memory; otherwise
// addresses alias modulo 16 and PSLVERR is tied low.
module apb_mem_ctrl #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MEM_DEPTH = 16,
   parameter int unsigned DATA_W    = 8
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic [3:0]        mem_addr,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned MEM_AW = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_DONE = 3'd2,
      RD      = 3'd3,
      RD_DONE = 3'd4,
      ERR     = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [MEM_AW-1:0]   addr_q,  addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                write_q, write_d;
   logic                wen_q,   wen_d;
   logic                ren_q,   ren_d;
   logic                pready_q, pready_d;
   logic                pslverr_q, pslverr_d;
   logic                out_range_c;
   logic                err_sel_c;

   // Setup-phase address lies beyond the populated memory
   assign out_range_c = (paddr >= ADDR_W'(MEM_DEPTH));

`ifdef APB_MEM_ADDR_CHECK_EN
   // Out-of-range setups are steered to the error response
   assign err_sel_c = out_range_c;
`else
   // No range check: upper address bits alias, error state is unreachable
   logic unused_addr_bits;
   assign err_sel_c        = 1'b0;
   assign unused_addr_bits = ^{paddr[ADDR_W-1:MEM_AW], out_range_c};
`endif

   // Captured direction is informational only; sequencing uses the state
   logic unused_write;
   assign unused_write = write_q;

   // Next-state, capture and registered-output decode
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      wen_d     = 1'b0;
      ren_d     = 1'b0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               addr_d  = paddr[MEM_AW-1:0];
               wdata_d = pwdata;
               write_d = pwrite;
               if (err_sel_c)   state_d = ERR;
               else if (pwrite) state_d = WR;
               else             state_d = RD;
            end
         end
         WR:      state_d = WR_DONE;
         WR_DONE: state_d = IDLE;
         RD:      state_d = RD_DONE;
         RD_DONE: state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      wen_d    = (state_d == WR);
      ren_d    = (state_d == RD);
      pready_d = (state_d == WR_DONE) || (state_d == RD_DONE) || (state_d == ERR);
`ifdef APB_MEM_ADDR_CHECK_EN
      pslverr_d = (state_d == ERR);
`else
      pslverr_d = 1'b0;
`endif
   end

   // State, captures and output flops with synchronous reset
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         wen_q     <= 1'b0;
         ren_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         write_q   <= write_d;
         wen_q     <= wen_d;
         ren_q     <= ren_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wen   = wen_q;
   assign mem_ren   = ren_q;
   assign pready    = pready_q;
   assign pslverr   = pslverr_q;

   // Macro data is valid only in the cycle after RD; gate it to zero elsewhere
   assign prdata = (state_q == RD_DONE) ? mem_rdata : '0;

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// tb_apb_mem_ctrl: directed bench for apb_mem_ctrl with a behavioural model of
// the 16x8 registered-read memory macro and a read-data scoreboard queue.
module tb_apb_mem_ctrl;

   logic       pclk = 1'b0;
   logic       rst_n;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata, prdata;
   logic       pready, pslverr;
   logic [3:0] mem_addr;
   logic       mem_wen, mem_ren;
   logic [7:0] mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] mem [16];

`ifdef APB_MEM_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   apb_mem_ctrl dut (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .mem_addr  (mem_addr),
      .mem_wen   (mem_wen),
      .mem_ren   (mem_ren),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 pclk = ~pclk;

   // Memory macro model: write at edge, registered read data
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'(8'hC0 + i);
      mem_rdata = 8'h00;
   end

   always @(posedge pclk) begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Continuous monitor: write-pulse shape, write gap, prdata gating
   logic wen_prev;
   int   low_run;
   bit   seen_pulse;
   always @(negedge pclk) begin
      if (!rst_n) begin
         wen_prev   = 1'b0;
         low_run    = 0;
         seen_pulse = 1'b0;
      end else begin
         if (mem_wen) begin
            check("wen_single_cycle", 32'(wen_prev), 0);
            if (!wen_prev && seen_pulse) check("wen_low_gap_ge2", 32'(low_run >= 2), 1);
            seen_pulse = 1'b1;
            low_run    = 0;
         end else begin
            low_run++;
         end
         if (!pready) check("prdata_zero_idle", prdata, 0);
         wen_prev = mem_wen;
      end
   end

   task automatic idle(input int n);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (n) @(posedge pclk);
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [7:0] d,
                            input bit expect_err, input bit drop_psel);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(posedge pclk); #1;
      if (drop_psel) begin psel = 1'b0; penable = 1'b0; end
      else penable = 1'b1;
      @(negedge pclk);
      if (expect_err) begin
         check("err_pready", pready, 1);
         check("err_pslverr", pslverr, 1);
         check("err_no_wen", mem_wen, 0);
         check("err_prdata", prdata, 0);
         return;
      end
      check("wr_wen", mem_wen, 1);
      check("wr_addr", mem_addr, a[3:0]);
      check("wr_wdata", mem_wdata, d);
      check("wr_wait", pready, 0);
      @(negedge pclk);
      check("wr_pready", pready, 1);
      check("wr_pslverr", pslverr, 0);
      check("wr_wen_off", mem_wen, 0);
   endtask

   task automatic apb_read(input logic [7:0] a, input logic [7:0] exp_data);
      int waited;
      logic [7:0] e;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      exp_q.push_back(exp_data);
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check("rd_ren", mem_ren, 1);
      check("rd_addr", mem_addr, a[3:0]);
      waited = 1;
      while (!pready && waited < 5) begin
         @(negedge pclk);
         waited++;
      end
      check("rd_access_cycles", waited, 2);
      e = exp_q.pop_front();
      check("rd_data", prdata, e);
      check("rd_pslverr", pslverr, 0);
      check("rd_ren_off", mem_ren, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'h00; pwdata = 8'h00;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("rst_prdata", prdata, 0);
      check("rst_pready", pready, 0);
      check("rst_pslverr", pslverr, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wen", mem_wen, 0);
      check("rst_mem_ren", mem_ren, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      @(posedge pclk); #1;
      rst_n = 1'b1;

      // Unwritten location returns macro content
      apb_read(8'h07, 8'hC7);

      // Write then read back
      apb_write(8'h03, 8'hA5, 1'b0, 1'b0);
      apb_read(8'h03, 8'hA5);
      idle(2);

      // Back-to-back writes, then reads
      apb_write(8'h00, 8'h11, 1'b0, 1'b0);
      apb_write(8'h0F, 8'h22, 1'b0, 1'b0);
      apb_read(8'h00, 8'h11);
      apb_read(8'h0F, 8'h22);
      idle(1);

      // Out-of-range write: rejected with error, or aliased onto address 0
      apb_write(8'h10, 8'h5A, CHK, 1'b0);
      apb_read(8'h00, CHK ? 8'h11 : 8'h5A);
      idle(1);

      // Access phase without setup is ignored
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'hFF;
      repeat (4) begin
         @(negedge pclk);
         check("noset_wen", mem_wen, 0);
         check("noset_ren", mem_ren, 0);
         check("noset_pready", pready, 0);
      end
      idle(1);
      apb_read(8'h02, 8'hC2);
      idle(1);

      // Master abort in WR still completes the write
      apb_write(8'h09, 8'h3C, 1'b0, 1'b1);
      idle(1);
      apb_read(8'h09, 8'h3C);

      // Reset during RD aborts to IDLE with all outputs low
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check("abort_rd_ren", mem_ren, 1);
      #1;
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      rst_n = 1'b1;
      @(negedge pclk);
      check("rst2_prdata", prdata, 0);
      check("rst2_pready", pready, 0);
      check("rst2_pslverr", pslverr, 0);
      check("rst2_mem_addr", mem_addr, 0);
      check("rst2_mem_wen", mem_wen, 0);
      check("rst2_mem_ren", mem_ren, 0);
      check("rst2_mem_wdata", mem_wdata, 0);

      // Macro contents survive controller reset
      apb_read(8'h03, 8'hA5);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
